// File: rtl/canonical_huffman_decoder.sv
// Bit-serial canonical Huffman decoder. The host loads per-length code counts and the
// canonically ordered symbol list; code bits arrive one per cycle, symbols leave under valid/ready.
module canonical_huffman_decoder #(
  parameter  int SYM_W   = 8,
  parameter  int NSYM    = 256,
  parameter  int MAX_LEN = 12,
  localparam int IW      = $clog2(NSYM) + 1,
  localparam int LW      = $clog2(MAX_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_len_we,
  input  logic [LW-1:0]    cfg_len_idx,
  input  logic [IW-1:0]    cfg_len_cnt,
  input  logic             cfg_sym_we,
  input  logic [IW-2:0]    cfg_sym_addr,
  input  logic [SYM_W-1:0] cfg_sym_data,
  input  logic             start,
  input  logic             flush,
  input  logic             in_valid,
  input  logic             in_bit,
  output logic             in_ready,
  output logic             sym_valid,
  output logic [SYM_W-1:0] sym_data,
  input  logic             sym_ready,
  output logic             busy,
  output logic             err
);
  localparam int CW   = MAX_LEN + 1;
  localparam int NLEN = 1 << LW;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DECODE = 2'd1,
    ST_ERR    = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CW-3:0]    code_q, code_d;
  logic [CW-1:0]    first_q, first_d;
  logic [IW-1:0]    index_q, index_d;
  logic [LW-1:0]    len_q, len_d;
  logic             sym_valid_q, sym_valid_d;
  logic [SYM_W-1:0] sym_data_q, sym_data_d;
  logic [IW-1:0]    count_q [NLEN];
  logic [SYM_W-1:0] sym_mem_q [NSYM];

  logic             cfg_open_s;
  logic             len_ok_s;
  logic             accept_s;
  logic             pop_s;
  logic             match_s;
  logic [IW-1:0]    count_cur_s;
  logic [CW-1:0]    code_ext_s;
  logic [CW-1:0]    diff_s;
  logic [CW-1:0]    first_sum_s;
  logic [IW-2:0]    sym_addr_s;

  // Datapath: the candidate code of the current length and its offset into that length's block.
  always_comb begin
    cfg_open_s  = (state_q == ST_IDLE) && !flush;
    len_ok_s    = (cfg_len_idx != {LW{1'b0}}) && (cfg_len_idx <= LW'(MAX_LEN));
    count_cur_s = count_q[len_q];
    code_ext_s  = {1'b0, code_q, in_bit};
    diff_s      = code_ext_s - first_q;
    match_s     = diff_s < CW'(count_cur_s);
    first_sum_s = first_q + CW'(count_cur_s);
    sym_addr_s  = index_q[IW-2:0] + diff_s[IW-2:0];
    in_ready    = (state_q == ST_DECODE) && (!sym_valid_q || sym_ready);
    accept_s    = in_valid && in_ready;
    pop_s       = sym_valid_q && sym_ready;
  end

  // Next-state: decode step per accepted bit, output slot handshake, flush override.
  always_comb begin
    state_d     = state_q;
    code_d      = code_q;
    first_d     = first_q;
    index_d     = index_q;
    len_d       = len_q;
    sym_data_d  = sym_data_q;
    if (pop_s) begin
      sym_valid_d = 1'b0;
    end else begin
      sym_valid_d = sym_valid_q;
    end
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_DECODE;
          code_d  = {(CW-2){1'b0}};
          first_d = {CW{1'b0}};
          index_d = {IW{1'b0}};
          len_d   = LW'(1);
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DECODE: begin
        if (accept_s && match_s) begin
          sym_valid_d = 1'b1;
          sym_data_d  = sym_mem_q[sym_addr_s];
          code_d      = {(CW-2){1'b0}};
          first_d     = {CW{1'b0}};
          index_d     = {IW{1'b0}};
          len_d       = LW'(1);
        end else if (accept_s && (len_q == LW'(MAX_LEN))) begin
          state_d = ST_ERR;
        end else if (accept_s) begin
          index_d = index_q + count_cur_s;
          // first is advanced to the next length's block base before the next compare
          first_d = first_sum_s << 1'b1;
          code_d  = code_ext_s[CW-3:0];
          len_d   = len_q + LW'(1);
        end else begin
          state_d = ST_DECODE;
        end
      end
      ST_ERR: begin
        state_d = ST_ERR;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if (flush) begin
      state_d     = ST_IDLE;
      sym_valid_d = 1'b0;
      code_d      = {(CW-2){1'b0}};
      first_d     = {CW{1'b0}};
      index_d     = {IW{1'b0}};
      len_d       = LW'(1);
    end else begin
      sym_valid_d = sym_valid_d;
    end
  end

  // Control and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      code_q      <= {(CW-2){1'b0}};
      first_q     <= {CW{1'b0}};
      index_q     <= {IW{1'b0}};
      len_q       <= LW'(1);
      sym_valid_q <= 1'b0;
      sym_data_q  <= {SYM_W{1'b0}};
    end else begin
      state_q     <= state_d;
      code_q      <= code_d;
      first_q     <= first_d;
      index_q     <= index_d;
      len_q       <= len_d;
      sym_valid_q <= sym_valid_d;
      sym_data_q  <= sym_data_d;
    end
  end

  // Per-length code counts; only writable while idle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NLEN; i++) begin
        count_q[i] <= {IW{1'b0}};
      end
    end else if (cfg_open_s && cfg_len_we && len_ok_s) begin
      count_q[cfg_len_idx] <= cfg_len_cnt;
    end
  end

  // Symbol table has no reset so it can map onto plain RAM.
  always_ff @(posedge clk) begin
    if (cfg_open_s && cfg_sym_we) begin
      sym_mem_q[cfg_sym_addr] <= cfg_sym_data;
    end
  end

  assign sym_valid = sym_valid_q;
  assign sym_data  = sym_data_q;
  assign busy      = (state_q != ST_IDLE);
  assign err       = (state_q == ST_ERR);

endmodule

// File: tb/tb_canonical_huffman_decoder.sv
// Self-checking bench: a dictionary-based canonical Huffman model predicts every output each cycle.
module tb_canonical_huffman_decoder;
  localparam int SYM_W   = 8;
  localparam int NSYM    = 256;
  localparam int MAX_LEN = 12;
  localparam int IW      = 9;
  localparam int LW      = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cfg_len_we = 1'b0;
  logic [LW-1:0]    cfg_len_idx = '0;
  logic [IW-1:0]    cfg_len_cnt = '0;
  logic             cfg_sym_we = 1'b0;
  logic [IW-2:0]    cfg_sym_addr = '0;
  logic [SYM_W-1:0] cfg_sym_data = '0;
  logic             start = 1'b0;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_bit = 1'b0;
  logic             in_ready;
  logic             sym_valid;
  logic [SYM_W-1:0] sym_data;
  logic             sym_ready = 1'b1;
  logic             busy;
  logic             err;

  always #5 clk = ~clk;

  canonical_huffman_decoder dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_len_we(cfg_len_we), .cfg_len_idx(cfg_len_idx), .cfg_len_cnt(cfg_len_cnt),
    .cfg_sym_we(cfg_sym_we), .cfg_sym_addr(cfg_sym_addr), .cfg_sym_data(cfg_sym_data),
    .start(start), .flush(flush),
    .in_valid(in_valid), .in_bit(in_bit), .in_ready(in_ready),
    .sym_valid(sym_valid), .sym_data(sym_data), .sym_ready(sym_ready),
    .busy(busy), .err(err)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference model: canonical codes enumerated into a (length,code)->symbol dictionary.
  typedef enum {M_IDLE, M_DEC, M_ERR} mstate_t;
  mstate_t    ms = M_IDLE;
  int         m_cnt [16];
  logic [7:0] m_sym [NSYM];
  logic [7:0] dict [int];
  logic [7:0] exp_q [$];
  int         acc_val = 0;
  int         acc_len = 0;
  logic [7:0] m_last = 8'h00;
  bit         known = 1'b0;
  bit         m_acc = 1'b0;
  bit         checks_on = 1'b0;
  logic       bq [$];

  function automatic void build_dict();
    int code = 0;
    int idx = 0;
    dict.delete();
    for (int l = 1; l <= MAX_LEN; l++) begin
      for (int k = 0; k < m_cnt[l]; k++) begin
        dict[l * 8192 + code] = m_sym[idx];
        code++;
        idx++;
      end
      code = code * 2;
    end
  endfunction

  function automatic void model_bit(input logic b);
    int key;
    acc_val = acc_val * 2 + int'(b);
    acc_len++;
    key = acc_len * 8192 + acc_val;
    if (dict.exists(key)) begin
      exp_q.push_back(dict[key]);
      m_last = dict[key];
      known = 1'b1;
      acc_val = 0;
      acc_len = 0;
    end else if (acc_len >= MAX_LEN) begin
      ms = M_ERR;
    end
  endfunction

  task automatic tick();
    logic mir;
    @(negedge clk);
    mir = (ms == M_DEC) && (exp_q.size() == 0 || sym_ready);
    if (checks_on) begin
      check_eq("in_ready", in_ready, mir);
      check_eq("sym_valid", sym_valid, exp_q.size() != 0);
      check_eq("busy", busy, ms != M_IDLE);
      check_eq("err", err, ms == M_ERR);
      if (known) check_eq("sym_data", sym_data, m_last);
    end
    m_acc = in_valid && mir && rst_n;
    if (!rst_n) begin
      ms = M_IDLE; exp_q.delete(); acc_val = 0; acc_len = 0;
      m_last = 8'h00; known = 1'b1;
      for (int i = 0; i < 16; i++) m_cnt[i] = 0;
    end else if (flush) begin
      ms = M_IDLE; exp_q.delete(); acc_val = 0; acc_len = 0; known = 1'b0;
    end else begin
      if (exp_q.size() != 0 && sym_ready) void'(exp_q.pop_front());
      case (ms)
        M_IDLE: begin
          if (cfg_len_we && cfg_len_idx >= 1 && cfg_len_idx <= MAX_LEN)
            m_cnt[cfg_len_idx] = int'(cfg_len_cnt);
          if (cfg_sym_we) m_sym[cfg_sym_addr] = cfg_sym_data;
          if (start) begin
            build_dict(); ms = M_DEC; acc_val = 0; acc_len = 0;
          end
        end
        M_DEC: if (m_acc) model_bit(in_bit);
        default: ;
      endcase
    end
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst_n = 1'b0; tick(); checks_on = 1'b1; tick(); rst_n = 1'b1;
  endtask

  task automatic start_pulse();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic flush_pulse();
    flush = 1'b1; tick(); flush = 1'b0;
  endtask

  task automatic load_table(input int cnts [MAX_LEN+1], input logic [7:0] syms [$]);
    for (int l = 1; l <= MAX_LEN; l++) begin
      cfg_len_we = 1'b1; cfg_len_idx = LW'(l); cfg_len_cnt = IW'(cnts[l]); tick();
    end
    cfg_len_we = 1'b0;
    for (int i = 0; i < syms.size(); i++) begin
      cfg_sym_we = 1'b1; cfg_sym_addr = (IW-1)'(i); cfg_sym_data = syms[i]; tick();
    end
    cfg_sym_we = 1'b0;
  endtask

  task automatic load_a();
    int c [MAX_LEN+1];
    logic [7:0] s [$];
    for (int i = 0; i <= MAX_LEN; i++) c[i] = 0;
    c[1] = 1; c[2] = 1; c[3] = 2;
    s = '{8'h41, 8'h42, 8'h43, 8'h44};
    load_table(c, s);
  endtask

  // mode: 0 ready high, 1 random valid/ready, 2 ready low for 8 cycles then high, 3 ready low
  task automatic send(input int mode);
    int budget = bq.size() * 8 + 60;
    int cyc = 0;
    while (bq.size() != 0 && budget > 0) begin
      in_valid  = (mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
      in_bit    = bq[0];
      case (mode)
        0: sym_ready = 1'b1;
        1: sym_ready = ($urandom_range(0, 2) != 0);
        2: sym_ready = (cyc >= 8);
        default: sym_ready = 1'b0;
      endcase
      tick();
      if (m_acc) void'(bq.pop_front());
      budget--; cyc++;
    end
    in_valid = 1'b0;
    if (bq.size() != 0) check_eq("send_timeout", bq.size(), 0);
  endtask

  task automatic drain();
    in_valid = 1'b0; sym_ready = 1'b1;
    repeat (3) tick();
  endtask

  task automatic push_ones(input int n);
    bq.delete();
    for (int i = 0; i < n; i++) bq.push_back(1'b1);
  endtask

  initial begin
    int c [MAX_LEN+1];
    logic [7:0] s [$];
    int enc_code [NSYM];
    int enc_len [NSYM];

    reset_dut();
    tick();

    load_a(); start_pulse();
    bq = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    send(0); drain();

    bq = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    send(2); drain();

    flush_pulse(); reset_dut();
    start_pulse(); push_ones(MAX_LEN); send(0);
    tick(); check_eq("err_after_12", err, 1'b1);
    flush_pulse(); tick();

    load_a(); start_pulse();
    bq = '{1'b1, 1'b1}; send(0);
    flush_pulse(); start_pulse();
    bq = '{1'b0}; send(0); drain();

    bq = '{1'b0}; send(3); tick();
    rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
    start_pulse(); push_ones(MAX_LEN); send(0); tick();
    flush_pulse();

    load_a(); start_pulse();
    cfg_len_we = 1'b1; cfg_len_idx = 4'd1; cfg_len_cnt = 9'd0; tick(); cfg_len_we = 1'b0;
    bq = '{1'b0}; send(0); drain();
    flush_pulse();

    for (int t = 0; t < 4; t++) begin
      int avail = 2;
      int total = 0;
      int code = 0;
      int idx = 0;
      for (int l = 1; l <= MAX_LEN; l++) begin
        int mx = (avail < NSYM - total) ? avail : NSYM - total;
        c[l] = $urandom_range(0, mx);
        total += c[l];
        avail = (avail - c[l]) * 2;
      end
      if (total == 0) begin c[1] = 1; total = 1; end
      s.delete();
      for (int i = 0; i < total; i++) s.push_back(8'($urandom));
      for (int l = 1; l <= MAX_LEN; l++) begin
        for (int k = 0; k < c[l]; k++) begin
          enc_code[idx] = code; enc_len[idx] = l; code++; idx++;
        end
        code = code * 2;
      end
      load_table(c, s);
      start_pulse();
      bq.delete();
      for (int n = 0; n < 30; n++) begin
        int pick = $urandom_range(0, total - 1);
        for (int b = enc_len[pick] - 1; b >= 0; b--) bq.push_back(1'((enc_code[pick] >> b) & 1));
      end
      send(1); drain();
      flush_pulse();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/canonical_huffman_decoder.md
# canonical_huffman_decoder

Bit-serial canonical Huffman decoder: the receive-side counterpart of the sorting/encoding path, turning a code bitstream back into symbols. A host loads the per-length code counts and the canonically ordered symbol list, then bits stream in one per cycle and decoded symbols stream out under valid/ready. It sits after the bitstream deserializer and before the symbol sink.

## Interface
- SYM_W, 8: symbol width.
- NSYM, 256: symbol table depth; IW = $clog2(NSYM)+1 index/count width.
- MAX_LEN, 12: longest legal code length; LW = $clog2(MAX_LEN+1).
- clk  in  1  clock, all logic rising-edge.
- rst_n  in  1  synchronous, active-low reset.
- cfg_len_we  in  1  write code count for one length (IDLE only).
- cfg_len_idx  in  LW  length 1..MAX_LEN; 0 and >MAX_LEN ignored.
- cfg_len_cnt  in  IW  number of codes of that length.
- cfg_sym_we  in  1  write symbol table entry (IDLE only).
- cfg_sym_addr  in  IW-1  canonical index.
- cfg_sym_data  in  SYM_W  symbol at that index.
- start  in  1  pulse; IDLE -> DECODE.
- flush  in  1  pulse; any state -> IDLE, drops partial code and pending symbol.
- in_valid  in  1  in_bit valid.
- in_bit  in  1  next code bit, MSB of code first.
- in_ready  out  1  bit accepted when in_valid && in_ready.
- sym_valid  out  1  decoded symbol held.
- sym_data  out  SYM_W  decoded symbol.
- sym_ready  in  1  sink accepts.
- busy  out  1  state != IDLE.
- err  out  1  invalid code seen (sticky until flush/reset).

## Operation
- States: IDLE, DECODE, ERR.
- IDLE: config writes take effect; writes in other states ignored. start -> DECODE with code=0, first=0, index=0, len=1.
- DECODE, per accepted bit: c = (code<<1)|in_bit; if (c - first) < count[len] (unsigned, MAX_LEN+1 bits): output sym_table[index + c - first], reset code/first/index/len to 0/0/0/1. Else: index += count[len]; first = (first + count[len]) << 1; code = c; len += 1.
- Note first is shifted before compare of next length: compare always uses first for current len; initial first=0 for len=1.
- If no match at len==MAX_LEN -> ERR: err=1, in_ready=0; pending sym_valid still drains.
- flush beats start and all other activity; from ERR returns to IDLE and clears err. Tables retained.
- Counts cleared to 0 by reset; symbol table not reset (contents X until written).

## Timing
- Reset values: in_ready=0, sym_valid=0, sym_data=0, busy=0, err=0, state IDLE, all counts 0.
- in_ready = (state==DECODE) && (!sym_valid || sym_ready), combinational; max one bit per cycle.
- Symbol of length L: sym_valid rises the cycle after its L-th bit is accepted; throughput one bit/cycle with no bubble between codes.
- sym_valid/sym_data held stable until sym_ready; simultaneous pop and new symbol load in the same cycle is legal and keeps sym_valid=1.
- start while DECODE/ERR ignored. cfg write and start in same cycle: write lands, decode uses new value.
- Reset mid-decode: next cycle all outputs at reset values, partial code lost.

## Test plan
- Load count[1]=1, count[2]=1, count[3]=2, syms {0x41,0x42,0x43,0x44}; start; bits 0,1,0,1,1,0,1,1,1 -> symbols 0x41,0x42,0x43,0x44 in order, each valid one cycle after final bit.
- Same tables, sym_ready=0 after first symbol -> in_ready drops, sym_data holds 0x41; raise sym_ready -> stream resumes, no bit lost or duplicated.
- All counts 0, start, feed MAX_LEN=12 ones -> err=1 and state ERR after 12th bit; in_ready=0; flush -> err=0, busy=0.
- Mid-code (after bits 1,1) assert flush then start, bits 0 -> 0x41 (partial code discarded).
- rst_n low during DECODE with sym_valid=1 -> next cycle sym_valid=0, busy=0, counts 0; start with zero counts then 12 bits -> err.
- Config writes during DECODE (count[1]=0) ignored: bit 0 still decodes to 0x41.
